// File: rtl/wb_resp_pkg.sv
// Shared definitions for the Wishbone fair responder: cycle/burst type codes,
// the per-channel FSM state type and the burst address sequencer.
package wb_resp_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  // Next beat address of a burst: wrapping bursts only advance the low
  // 2/3/4 address bits and leave the upper bits untouched.
  function automatic logic [63:0] wb_next_adr(input logic [63:0] adr, input logic [1:0] bte);
    logic [63:0] inc;
    inc = adr + 64'd1;
    case (bte)
      BTE_WRAP4:  wb_next_adr = {adr[63:2], inc[1:0]};
      BTE_WRAP8:  wb_next_adr = {adr[63:3], inc[2:0]};
      BTE_WRAP16: wb_next_adr = {adr[63:4], inc[3:0]};
      default:    wb_next_adr = inc;
    endcase
  endfunction

endpackage

// File: rtl/wb_resp_chan.sv
// One Wishbone responder channel: bounded-wait ack generation, transaction
// FSM, hold-register protocol checks and a saturating beat counter.
// Optional feature macro: WB_RESP_ERR_EN (enables err responses from rand_err).
module wb_resp_chan
  import wb_resp_pkg::*;
#(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = DATA_W / 8,
  parameter int MAX_WAIT = 1,
  parameter int CNT_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cyc,
  input  logic              stb,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [SEL_W-1:0]  sel,
  input  logic [2:0]        cti,
  input  logic [1:0]        bte,
  input  logic              rand_ack,
  input  logic              rand_err,
  input  logic [DATA_W-1:0] rand_dat,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] dat_r,
  output logic              stall,
  output logic              viol,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t              r_state;
  state_t              w_nextState;
  logic [WAIT_W-1:0]   r_waitCnt;
  logic [ADDR_W-1:0]   r_holdAdr;
  logic                r_holdWe;
  logic [SEL_W-1:0]    r_holdSel;
  logic [2:0]          r_holdCti;
  logic [1:0]          r_holdBte;
  logic                r_viol;
  logic [CNT_W-1:0]    r_beatCnt;

  logic                w_pend;
  logic                w_atBound;
  logic                w_resp;
  logic                w_err;
  logic                w_violSet;
  logic [ADDR_W-1:0]   w_expAdr;

  // Reset gates pend so every response output drops the moment reset rises.
  assign w_pend    = cyc & stb & ~reset;
  assign w_atBound = (r_waitCnt == WAIT_MAX);
  assign w_resp    = w_pend & (rand_ack | w_atBound);
  assign w_expAdr  = ADDR_W'(wb_next_adr(64'(r_holdAdr), r_holdBte));

`ifdef WB_RESP_ERR_EN
  assign w_err = w_resp & rand_err;
`else
  logic w_unusedErr;
  assign w_unusedErr = rand_err;
  assign w_err       = 1'b0;
`endif

  assign ack      = w_resp & ~w_err;
  assign err      = w_err;
  assign dat_r    = (w_resp & ~we) ? rand_dat : '0;
  assign stall    = w_pend & ~rand_ack & w_atBound;
  assign viol     = r_viol;
  assign beat_cnt = r_beatCnt;

  // State register for the transaction FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state decode plus detection of master protocol violations.
  always_comb begin
    w_nextState = r_state;
    w_violSet   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pend) begin
          if (!w_resp)                        w_nextState = WAIT;
          else if (cti == CTI_INCR && !w_err) w_nextState = BURST;
        end
      end
      WAIT: begin
        if (!cyc) begin
          w_nextState = IDLE;
        end else begin
          if (!stb || adr != r_holdAdr || we != r_holdWe || sel != r_holdSel)
            w_violSet = 1'b1;
          if (w_resp)
            w_nextState = (r_holdCti == CTI_INCR && !w_err) ? BURST : IDLE;
        end
      end
      BURST: begin
        if (!cyc) begin
          w_nextState = IDLE;
        end else if (w_pend) begin
          if (adr != w_expAdr || we != r_holdWe) w_violSet = 1'b1;
          if (w_resp && (cti == CTI_EOB || w_err)) w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Hold registers: captured at the first beat, advanced on each burst beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_holdAdr <= '0;
      r_holdWe  <= 1'b0;
      r_holdSel <= '0;
      r_holdCti <= CTI_CLASSIC;
      r_holdBte <= BTE_LINEAR;
    end else if (r_state == IDLE && w_pend) begin
      r_holdAdr <= adr;
      r_holdWe  <= we;
      r_holdSel <= sel;
      r_holdCti <= cti;
      r_holdBte <= bte;
    end else if (r_state == BURST && w_resp) begin
      r_holdAdr <= adr;
      r_holdCti <= cti;
    end
  end

  // Wait-state counter that forces a response once it reaches MAX_WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                r_waitCnt <= '0;
    else if (w_pend && !w_resp) r_waitCnt <= r_waitCnt + WAIT_W'(1);
    else                      r_waitCnt <= '0;
  end

  // Saturating count of responded beats within the current cyc.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                r_beatCnt <= '0;
    else if (!cyc)                            r_beatCnt <= '0;
    else if (w_resp && r_beatCnt != CNT_MAX)  r_beatCnt <= r_beatCnt + CNT_W'(1);
  end

  // Sticky violation flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          r_viol <= 1'b0;
    else if (w_violSet) r_viol <= 1'b1;
  end

endmodule

// File: rtl/wb_fair_responder.sv
// Multi-channel Wishbone classic responder for harnesses: NCHAN independent
// channels, each with a hardware wait bound, burst tracking and violation flag.
// Optional feature macro: WB_RESP_ERR_EN (err responses driven by rand_err).
module wb_fair_responder
  import wb_resp_pkg::*;
#(
  parameter int NCHAN    = 2,
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 1,
  parameter int CNT_W    = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NCHAN-1:0]              cyc,
  input  logic [NCHAN-1:0]              stb,
  input  logic [NCHAN-1:0]              we,
  input  logic [NCHAN*ADDR_W-1:0]       adr,
  input  logic [NCHAN*(DATA_W/8)-1:0]   sel,
  input  logic [NCHAN*3-1:0]            cti,
  input  logic [NCHAN*2-1:0]            bte,
  input  logic [NCHAN-1:0]              rand_ack,
  input  logic [NCHAN-1:0]              rand_err,
  input  logic [NCHAN*DATA_W-1:0]       rand_dat,
  output logic [NCHAN-1:0]              ack,
  output logic [NCHAN-1:0]              err,
  output logic [NCHAN*DATA_W-1:0]       dat_r,
  output logic [NCHAN-1:0]              stall,
  output logic [NCHAN-1:0]              viol,
  output logic [NCHAN*CNT_W-1:0]        beat_cnt
);

  localparam int SEL_W = DATA_W / 8;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    wb_resp_chan #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .SEL_W    (SEL_W),
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .cyc      (cyc[g]),
      .stb      (stb[g]),
      .we       (we[g]),
      .adr      (adr[g*ADDR_W +: ADDR_W]),
      .sel      (sel[g*SEL_W +: SEL_W]),
      .cti      (cti[g*3 +: 3]),
      .bte      (bte[g*2 +: 2]),
      .rand_ack (rand_ack[g]),
      .rand_err (rand_err[g]),
      .rand_dat (rand_dat[g*DATA_W +: DATA_W]),
      .ack      (ack[g]),
      .err      (err[g]),
      .dat_r    (dat_r[g*DATA_W +: DATA_W]),
      .stall    (stall[g]),
      .viol     (viol[g]),
      .beat_cnt (beat_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_wb_fair_responder.sv
// Self-checking bench for wb_fair_responder: directed scenarios followed by
// randomized master traffic, all checked against a transaction-level model.
// Honours WB_RESP_ERR_EN the same way the design does.
module tb_wb_fair_responder;
  import wb_resp_pkg::*;

  localparam int NCHAN    = 2;
  localparam int ADDR_W   = 30;
  localparam int DATA_W   = 32;
  localparam int SEL_W    = DATA_W / 8;
  localparam int MAX_WAIT = 2;
  localparam int CNT_W    = 4;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;
`ifdef WB_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                        clock, reset;
  logic [NCHAN-1:0]            cyc, stb, we, rand_ack, rand_err;
  logic [NCHAN*ADDR_W-1:0]     adr;
  logic [NCHAN*SEL_W-1:0]      sel;
  logic [NCHAN*3-1:0]          cti;
  logic [NCHAN*2-1:0]          bte;
  logic [NCHAN*DATA_W-1:0]     rand_dat, dat_r;
  logic [NCHAN-1:0]            ack, err, stall, viol;
  logic [NCHAN*CNT_W-1:0]      beat_cnt;

  // Per-channel drive values, packed onto the buses each cycle.
  logic              dCyc [NCHAN], dStb [NCHAN], dWe [NCHAN], dRack [NCHAN], dRerr [NCHAN];
  logic [ADDR_W-1:0] dAdr [NCHAN];
  logic [SEL_W-1:0]  dSel [NCHAN];
  logic [2:0]        dCti [NCHAN];
  logic [1:0]        dBte [NCHAN];
  logic [DATA_W-1:0] dRdat [NCHAN];

  // Reference model: open transaction kind, wait count, hold values, counters.
  int                mWait [NCHAN];
  bit                mFirstBeatOpen [NCHAN], mInBurst [NCHAN], mViol [NCHAN], mRespLast [NCHAN];
  int                mBeats [NCHAN];
  logic [ADDR_W-1:0] mHoldAdr [NCHAN];
  logic              mHoldWe [NCHAN];
  logic [SEL_W-1:0]  mHoldSel [NCHAN];
  logic [2:0]        mHoldCti [NCHAN];
  logic [1:0]        mHoldBte [NCHAN];

  // Random master state.
  bit                rOn [NCHAN];
  logic [ADDR_W-1:0] rAdr [NCHAN];
  logic              rWe [NCHAN];
  logic [SEL_W-1:0]  rSel [NCHAN];
  logic [2:0]        rCti [NCHAN];
  logic [1:0]        rBte [NCHAN];

  int compared   = 0;
  int mismatched = 0;

  wb_fair_responder #(
    .NCHAN(NCHAN), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .cti(cti), .bte(bte), .rand_ack(rand_ack), .rand_err(rand_err), .rand_dat(rand_dat),
    .ack(ack), .err(err), .dat_r(dat_r), .stall(stall), .viol(viol), .beat_cnt(beat_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic string chTag(input string n, input int c);
    return $sformatf("%s[%0d]", n, c);
  endfunction

  // Burst address rule stated arithmetically: wrap within an aligned block of 4/8/16.
  function automatic logic [ADDR_W-1:0] nextBurstAdr(input logic [ADDR_W-1:0] a, input logic [1:0] b);
    longint la, span;
    la = longint'(a);
    if (b == 2'b00) return ADDR_W'(la + 1);
    span = longint'(1) << (int'(b) + 1);
    return ADDR_W'(la - (la % span) + ((la + 1) % span));
  endfunction

  task automatic setChan(input int c, input logic cy, input logic st, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [2:0] ct, input logic [1:0] bt,
                         input logic ra, input logic re, input logic [DATA_W-1:0] rd);
    dCyc[c] = cy;  dStb[c] = st;  dWe[c] = w;  dAdr[c] = a;  dSel[c] = 4'hF;
    dCti[c] = ct;  dBte[c] = bt;  dRack[c] = ra;  dRerr[c] = re;  dRdat[c] = rd;
  endtask

  task automatic idleChan(input int c);
    setChan(c, 1'b0, 1'b0, 1'b0, '0, CTI_CLASSIC, BTE_LINEAR, 1'b0, 1'b0, '0);
  endtask

  task automatic packBuses();
    for (int c = 0; c < NCHAN; c++) begin
      cyc[c] = dCyc[c];  stb[c] = dStb[c];  we[c] = dWe[c];
      rand_ack[c] = dRack[c];  rand_err[c] = dRerr[c];
      adr[c*ADDR_W +: ADDR_W] = dAdr[c];
      sel[c*SEL_W +: SEL_W]   = dSel[c];
      cti[c*3 +: 3]           = dCti[c];
      bte[c*2 +: 2]           = dBte[c];
      rand_dat[c*DATA_W +: DATA_W] = dRdat[c];
    end
  endtask

  task automatic resetModel();
    for (int c = 0; c < NCHAN; c++) begin
      mWait[c] = 0;  mFirstBeatOpen[c] = 0;  mInBurst[c] = 0;  mViol[c] = 0;
      mRespLast[c] = 0;  mBeats[c] = 0;  mHoldAdr[c] = '0;  mHoldWe[c] = 0;
      mHoldSel[c] = '0;  mHoldCti[c] = CTI_CLASSIC;  mHoldBte[c] = BTE_LINEAR;
    end
  endtask

  // Compare every output against the model, then advance the model one edge.
  task automatic checkAndStep();
    for (int c = 0; c < NCHAN; c++) begin
      bit pend, atBound, resp, errE, violEv;
      logic [DATA_W-1:0] datE;
      pend    = dCyc[c] && dStb[c];
      atBound = (mWait[c] == MAX_WAIT);
      resp    = pend && (dRack[c] || atBound);
      errE    = ERR_EN && resp && dRerr[c];
      datE    = (resp && !dWe[c]) ? dRdat[c] : '0;
      checkOutput(chTag("ack", c), ack[c], resp && !errE);
      checkOutput(chTag("err", c), err[c], errE);
      checkOutput(chTag("stall", c), stall[c], pend && !dRack[c] && atBound);
      checkOutput(chTag("dat_r", c), dat_r[c*DATA_W +: DATA_W], datE);
      checkOutput(chTag("viol", c), viol[c], mViol[c]);
      checkOutput(chTag("beat_cnt", c), beat_cnt[c*CNT_W +: CNT_W], mBeats[c]);

      violEv = 0;
      if (mFirstBeatOpen[c] && dCyc[c] &&
          (!dStb[c] || dAdr[c] != mHoldAdr[c] || dWe[c] != mHoldWe[c] || dSel[c] != mHoldSel[c]))
        violEv = 1;
      if (mInBurst[c] && pend &&
          (dAdr[c] != nextBurstAdr(mHoldAdr[c], mHoldBte[c]) || dWe[c] != mHoldWe[c]))
        violEv = 1;

      if (!dCyc[c]) begin
        mFirstBeatOpen[c] = 0;  mInBurst[c] = 0;
      end else if (mFirstBeatOpen[c]) begin
        if (resp) begin
          mFirstBeatOpen[c] = 0;
          mInBurst[c] = (mHoldCti[c] == CTI_INCR) && !errE;
        end
      end else if (mInBurst[c]) begin
        if (resp) begin
          mHoldAdr[c] = dAdr[c];  mHoldCti[c] = dCti[c];
          if (dCti[c] == CTI_EOB || errE) mInBurst[c] = 0;
        end
      end else if (pend) begin
        mHoldAdr[c] = dAdr[c];  mHoldWe[c] = dWe[c];  mHoldSel[c] = dSel[c];
        mHoldCti[c] = dCti[c];  mHoldBte[c] = dBte[c];
        if (!resp) mFirstBeatOpen[c] = 1;
        else       mInBurst[c] = (dCti[c] == CTI_INCR) && !errE;
      end

      mWait[c] = (pend && !resp) ? mWait[c] + 1 : 0;
      if (!dCyc[c])                      mBeats[c] = 0;
      else if (resp && mBeats[c] < CNT_SAT) mBeats[c] = mBeats[c] + 1;
      if (violEv) mViol[c] = 1;
      mRespLast[c] = resp;
    end
  endtask

  task automatic applyStimulus();
    @(negedge clock);
    packBuses();
    #1;
    checkAndStep();
  endtask

  // Reset pulse between two edges: outputs must clear at once, then run the cycle.
  task automatic pulseReset();
    @(negedge clock);
    packBuses();
    #1 reset = 1'b1;
    #1;
    for (int c = 0; c < NCHAN; c++) begin
      checkOutput(chTag("rst_ack", c), ack[c], 0);
      checkOutput(chTag("rst_err", c), err[c], 0);
      checkOutput(chTag("rst_stall", c), stall[c], 0);
      checkOutput(chTag("rst_dat_r", c), dat_r[c*DATA_W +: DATA_W], 0);
      checkOutput(chTag("rst_viol", c), viol[c], 0);
      checkOutput(chTag("rst_beat_cnt", c), beat_cnt[c*CNT_W +: CNT_W], 0);
    end
    resetModel();
    reset = 1'b0;
    #1;
    checkAndStep();
  endtask

  task automatic newTx(input int c);
    rOn[c]  = 1;
    rAdr[c] = ADDR_W'($urandom_range(63, 0));
    rWe[c]  = 1'($urandom_range(1, 0));
    rSel[c] = SEL_W'($urandom);
    rCti[c] = ($urandom_range(1, 0) != 0) ? CTI_INCR : CTI_CLASSIC;
    rBte[c] = 2'($urandom);
  endtask

  task automatic randomDrive(input int c);
    if (!rOn[c]) begin
      if ($urandom_range(1, 0) != 0) newTx(c);
    end else if (mRespLast[c]) begin
      if (rCti[c] == CTI_INCR) begin
        rAdr[c] = nextBurstAdr(rAdr[c], rBte[c]);
        if ($urandom_range(3, 0) == 0) rCti[c] = CTI_EOB;
      end else if ($urandom_range(1, 0) != 0) begin
        rOn[c] = 0;
      end else begin
        newTx(c);
      end
    end
    if (rOn[c] && $urandom_range(31, 0) == 0) rOn[c] = 0;
    dCyc[c]  = rOn[c];
    dStb[c]  = rOn[c] && ($urandom_range(15, 0) != 0);
    dAdr[c]  = rAdr[c] ^ (($urandom_range(31, 0) == 0) ? ADDR_W'(1) : ADDR_W'(0));
    dWe[c]   = rWe[c];
    dSel[c]  = rSel[c];
    dCti[c]  = rCti[c];
    dBte[c]  = rBte[c];
    dRack[c] = ($urandom_range(2, 0) == 0);
    dRerr[c] = ($urandom_range(3, 0) == 0);
    dRdat[c] = $urandom;
  endtask

  initial begin
    logic [ADDR_W-1:0] burstAdr [4];
    logic [2:0]        burstCti [4];

    // Reset held with a pending, acked request: everything must stay quiet.
    reset = 1'b1;
    for (int c = 0; c < NCHAN; c++) idleChan(c);
    setChan(0, 1, 1, 0, 30'h5, CTI_CLASSIC, BTE_LINEAR, 1, 1, 32'hDEAD_BEEF);
    packBuses();
    resetModel();
    for (int c = 0; c < NCHAN; c++) rOn[c] = 0;
    #2;
    checkOutput("init_ack", ack[0], 0);
    checkOutput("init_err", err[0], 0);
    checkOutput("init_dat_r", dat_r[DATA_W-1:0], 0);
    checkOutput("init_viol", viol, 0);
    checkOutput("init_beat_cnt", beat_cnt, 0);
    @(negedge clock);
    idleChan(0);
    packBuses();
    reset = 1'b0;
    #1 checkAndStep();

    // Single read with no free ack: forced on the third pending cycle.
    for (int i = 0; i < 3; i++) begin
      setChan(0, 1, 1, 0, 30'h20, CTI_CLASSIC, BTE_LINEAR, 0, 0, 32'hA5A5_0001);
      applyStimulus();
      checkOutput($sformatf("t1_ack_c%0d", i), ack[0], (i == 2));
      checkOutput($sformatf("t1_stall_c%0d", i), stall[0], (i == 2));
    end
    checkOutput("t1_dat_r", dat_r[DATA_W-1:0], 32'hA5A5_0001);
    idleChan(0);
    applyStimulus();

    // Write acked on its first pend cycle; next beat must wait afresh.
    setChan(0, 1, 1, 1, 30'h30, CTI_CLASSIC, BTE_LINEAR, 1, 0, 32'h1234_5678);
    applyStimulus();
    checkOutput("t2_ack", ack[0], 1);
    checkOutput("t2_dat_r", dat_r[DATA_W-1:0], 0);
    checkOutput("t2_stall", stall[0], 0);
    setChan(0, 1, 1, 1, 30'h31, CTI_CLASSIC, BTE_LINEAR, 0, 0, 32'h0);
    applyStimulus();
    checkOutput("t2_next_ack", ack[0], 0);
    idleChan(0);
    applyStimulus();

    // Wrap-4 burst 6,7,4,5, then the same burst with a bad second address.
    burstCti = '{CTI_INCR, CTI_INCR, CTI_INCR, CTI_EOB};
    for (int rep = 0; rep < 2; rep++) begin
      burstAdr = '{30'h6, (rep == 0) ? 30'h7 : 30'h8, 30'h4, 30'h5};
      for (int i = 0; i < 4; i++) begin
        setChan(0, 1, 1, 0, burstAdr[i], burstCti[i], BTE_WRAP4, 1, 0, $urandom);
        applyStimulus();
        checkOutput($sformatf("t3_ack_r%0d_b%0d", rep, i), ack[0], 1);
      end
      setChan(0, 1, 0, 0, 30'h0, CTI_CLASSIC, BTE_LINEAR, 0, 0, 32'h0);
      applyStimulus();
      checkOutput($sformatf("t3_beat_cnt_r%0d", rep), beat_cnt[CNT_W-1:0], 4);
      checkOutput($sformatf("t3_viol_r%0d", rep), viol[0], rep);
      idleChan(0);
      applyStimulus();
      applyStimulus();
      checkOutput($sformatf("t3_beat_clr_r%0d", rep), beat_cnt[CNT_W-1:0], 0);
      checkOutput($sformatf("t3_viol_sticky_r%0d", rep), viol[0], rep);
    end

    // Address change while waiting; channel 1 runs a clean read alongside.
    for (int c = 0; c < NCHAN; c++) idleChan(c);
    pulseReset();
    for (int i = 0; i < 3; i++) begin
      setChan(0, 1, 1, 0, (i == 0) ? 30'h10 : 30'h11, CTI_CLASSIC, BTE_LINEAR, 0, 0, 32'h77);
      setChan(1, 1, 1, 0, 30'h40, CTI_CLASSIC, BTE_LINEAR, 0, 0, 32'h88);
      applyStimulus();
    end
    checkOutput("t4_viol_ch0", viol[0], 1);
    checkOutput("t4_viol_ch1", viol[1], 0);
    checkOutput("t4_ack_with_viol", ack[0], 1);

    // Reset between edges while waiting at the bound with viol set.
    idleChan(1);
    for (int i = 0; i < 2; i++) begin
      setChan(0, 1, 1, 0, 30'h50, CTI_CLASSIC, BTE_LINEAR, 0, 0, 32'h99);
      applyStimulus();
    end
    pulseReset();
    checkOutput("t6_no_residual_stall", stall[0], 0);
    idleChan(0);
    applyStimulus();

    // Error request on a write.
    setChan(1, 1, 1, 1, 30'h60, CTI_CLASSIC, BTE_LINEAR, 1, 1, 32'h0);
    applyStimulus();
    checkOutput("t5_err", err[1], ERR_EN);
    checkOutput("t5_ack", ack[1], !ERR_EN);
    idleChan(1);
    applyStimulus();

    // Long linear burst drives beat_cnt into saturation.
    for (int i = 0; i < CNT_SAT + 3; i++) begin
      setChan(1, 1, 1, 0, ADDR_W'(30'h100 + i), CTI_INCR, BTE_LINEAR, 1, 0, $urandom);
      applyStimulus();
    end
    setChan(1, 1, 0, 0, 30'h0, CTI_INCR, BTE_LINEAR, 0, 0, 32'h0);
    applyStimulus();
    checkOutput("sat_beat_cnt", beat_cnt[CNT_W +: CNT_W], CNT_SAT);
    checkOutput("sat_viol", viol[1], 0);
    idleChan(1);
    applyStimulus();

    // Randomized master traffic with periodic reset pulses.
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < NCHAN; c++) randomDrive(c);
      if (k % 100 == 99) pulseReset();
      else               applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
